// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
// Defining UART_TX_PARITY_EN enables the even-parity bit in the transmitter.
package uart_pkg;

  localparam int   DATA_BITS            = 8;
  localparam logic IDLE_LEVEL           = 1'b1;
  localparam int   DEFAULT_CLKS_PER_BIT = 10417;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } tx_state_t;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period timer for the UART transmitter: counts 0..CLKS_PER_BIT-1 and
// flags the last cycle of each bit period with bit_tick_o.
module uart_tx_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic bit_tick_o
);

  localparam int               CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: held at zero while cleared, wraps at the bit boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick_o = (cnt_q == CNT_MAX) && !clear_i;

endmodule

// File: rtl/uart_transmitter.sv
// UART serializer, 8N1 framing (start, 8 data bits LSB first, stop).
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 tx_start,
  output logic                 tx,
  output logic                 tx_done
);

  tx_state_t            state_q;
  tx_state_t            state_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [2:0]           bit_idx_q;
  logic [2:0]           bit_idx_d;
  logic                 tx_q;
  logic                 tx_d;
  logic                 tx_done_q;
  logic                 tx_done_d;
  logic                 bit_tick_s;
  logic                 cnt_clear_s;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
  logic                 parity_d;
`endif

  // The timer is held at zero while idle so the accepting edge starts a fresh bit period.
  assign cnt_clear_s = (state_q == IDLE);

  uart_tx_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clear_i   (cnt_clear_s),
    .bit_tick_o(bit_tick_s)
  );

  // Frame sequencing; tx_d is the line level for the cycle after this edge.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    tx_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = IDLE_LEVEL;
        if (tx_start) begin
          state_d   = START;
          shift_d   = data_in;
          bit_idx_d = 3'd0;
          tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d  = even_parity(data_in);
`endif
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_tick_s) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_tick_s) begin
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
            tx_d      = parity_q;
`else
            state_d   = STOP;
            tx_d      = IDLE_LEVEL;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick_s) begin
          state_d = STOP;
          tx_d    = IDLE_LEVEL;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        tx_d = IDLE_LEVEL;
        if (bit_tick_s) begin
          state_d   = IDLE;
          tx_done_d = 1'b1;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_idx_d = 3'd0;
        tx_d      = IDLE_LEVEL;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= 3'd0;
      tx_q      <= IDLE_LEVEL;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      tx_done_q <= tx_done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the accepted byte, kept because the shift register is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign tx      = tx_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter (fast instance at 4 clocks/bit plus a
// default-parameter instance); honours UART_TX_PARITY_EN for the frame model.
module tb_uart_transmitter;
  import uart_pkg::*;

  localparam int CPB     = 4;
  localparam int CPB_DEF = 10417;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic                 clk       = 1'b0;
  logic                 rst_n     = 1'b0;
  logic [DATA_BITS-1:0] data_in   = 8'h00;
  logic                 tx_start  = 1'b0;
  logic                 tx;
  logic                 tx_done;
  logic [DATA_BITS-1:0] data_def  = 8'h00;
  logic                 start_def = 1'b0;
  logic                 tx_def;
  logic                 done_def;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .tx_start(tx_start),
    .tx      (tx),
    .tx_done (tx_done)
  );

  uart_transmitter u_def (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_def),
    .tx_start(start_def),
    .tx      (tx_def),
    .tx_done (done_def)
  );

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t vecs[6];

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Line level for frame bit i: start, data LSB first, optional parity, stop.
  function automatic logic model_bit(input logic [7:0] d, input logic p, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (i == NB - 1) return 1'b1;
    return p;
  endfunction

  function automatic logic model_par(input logic [7:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  // Request a frame; the next rising edge is the accepting edge.
  task automatic start_frame(input logic [7:0] d);
    data_in  = d;
    tx_start = 1'b1;
  endtask

  // Walks the accepting edge through the tx_done edge, checking every cycle.
  task automatic check_frame(input string name, input logic [7:0] d, input logic p,
                             input int poke_at, input logic [7:0] poke_d, input bit keep_start);
    @(posedge clk); #1;
    if (!keep_start) tx_start = 1'b0;
    for (int c = 0; c <= FRAME; c++) begin
      if (c < FRAME) begin
        check1($sformatf("%s tx cyc%0d", name, c), tx, model_bit(d, p, c / CPB));
        check1($sformatf("%s done cyc%0d", name, c), tx_done, 1'b0);
      end else begin
        check1($sformatf("%s tx at end", name), tx, 1'b1);
        check1($sformatf("%s done at end", name), tx_done, 1'b1);
      end
      if (poke_at >= 0 && c == poke_at) begin
        data_in  = poke_d;
        tx_start = 1'b1;
      end else if (poke_at >= 0 && c == poke_at + 1) begin
        tx_start = 1'b0;
      end
      if (c < FRAME) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic check_idle(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      check1($sformatf("%s idle tx", name), tx, 1'b1);
      check1($sformatf("%s idle done", name), tx_done, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{8'hAA, 1'b0};
    vecs[1] = '{8'hF0, 1'b0};
    vecs[2] = '{8'h07, 1'b1};
    vecs[3] = '{8'h81, 1'b0};
    vecs[4] = '{8'h00, 1'b0};
    vecs[5] = '{8'hFE, 1'b1};

    // Reset held for two cycles, then idle with no request.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check1("reset tx", tx, 1'b1);
      check1("reset done", tx_done, 1'b0);
      check1("reset tx_def", tx_def, 1'b1);
      check1("reset done_def", done_def, 1'b0);
    end
    rst_n = 1'b1;
    check_idle("post-reset", 4);

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      start_frame(vecs[i].data);
      check_frame($sformatf("vec%0d_%02h", i, vecs[i].data), vecs[i].data, vecs[i].par, -1, 8'h00, 1'b0);
      check_idle($sformatf("vec%0d", i), 2);
    end

    // Request mid-frame must be ignored and not queued.
    start_frame(8'h3C);
    check_frame("busy_3C", 8'h3C, 1'b0, 2 * CPB + 1, 8'h55, 1'b0);
    check_idle("busy_3C", 3);

    // tx_start held through the frame re-triggers straight after tx_done.
    start_frame(8'hA5);
    check_frame("held_A5_1", 8'hA5, 1'b0, -1, 8'h00, 1'b1);
    check_frame("held_A5_2", 8'hA5, 1'b0, -1, 8'h00, 1'b0);
    check_idle("held_A5", 2);

    // Reset during the data bits: line returns to mark immediately, no tx_done.
    start_frame(8'h3C);
    @(posedge clk); #1;
    tx_start = 1'b0;
    repeat (2 * CPB + 1) @(posedge clk);
    #1;
    check1("pre-abort tx (data bit1 of 3C)", tx, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check1("abort tx async", tx, 1'b1);
    check1("abort done", tx_done, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check1("abort hold tx", tx, 1'b1);
      check1("abort hold done", tx_done, 1'b0);
    end
    rst_n = 1'b1;
    check_idle("after abort", 3);
    start_frame(8'h81);
    check_frame("after_abort_81", 8'h81, 1'b0, -1, 8'h00, 1'b0);
    check_idle("after_abort_81", 1);

    // Randomized frames against the model.
    for (int i = 0; i < 10; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      start_frame(d);
      check_frame($sformatf("rand%0d_%02h", i, d), d, model_par(d), -1, 8'h00, 1'b0);
      check_idle($sformatf("rand%0d", i), $urandom_range(0, 2));
    end

    // Default-parameter instance: start bit lasts exactly 10417 cycles.
    data_def  = 8'h01;
    start_def = 1'b1;
    @(posedge clk); #1;
    start_def = 1'b0;
    check1("def start bit first cycle", tx_def, 1'b0);
    repeat (CPB_DEF - 1) @(posedge clk);
    #1;
    check1("def start bit last cycle", tx_def, 1'b0);
    @(posedge clk); #1;
    check1("def data bit0", tx_def, 1'b1);
    check1("def done low", done_def, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
